mc_control: RTL and testbench
=============================

# mc_control

Multicycle MIPS main controller: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It sits directly upstream of the `mux4` operand and PC-source selectors, feeding their 2-bit `s` inputs through `alusrcb` and `pcsrc`. Memory accesses stall on a ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode from the instruction register, `instr[31:26]`
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- pcen  out  1  PC load; equals `pcwrite | (branch & zero)`
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select to `mux4`: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- pcsrc  out  2  PC source select to `mux4`: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  2  00 = add, 01 = subtract, 10 = decode funct
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-back data: 0 = ALUOut, 1 = memory data
- regdst  out  1  destination register: 0 = rt, 1 = rd
- illegal  out  1  one-cycle pulse in DECODE when `op` is unsupported

## Operation
Opcodes:
- R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.

Outputs are a pure function of state; `pcen` also uses `zero`. Any output not listed for a state is 0.

States and outputs:
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite = pcwrite = `mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Next state:
  - lw or sw → MEMADR
  - R-type → RTYPEEX
  - beq → BEQEX
  - addi → ADDIEX
  - j → JEX
  - any other opcode → FETCH, with `illegal`=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Waits on `mem_ready`, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR: iord=1, memwrite=1. Holds `memwrite` high until `mem_ready`, then goes to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX: pcsrc=10, pcwrite=1. Goes to FETCH.

Rules:
- State encoding is 4 bits. Unused encodings return to FETCH on the next edge.
- `op` is sampled only in DECODE and MEMADR. The instruction register is stable in those states.

## Timing
- Reset: `rst_n`=0 forces FETCH immediately, without waiting for a clock edge. Outputs then show the FETCH decode: alusrcb=01, all other outputs 0, and irwrite/pcen following `mem_ready`.
- Reset asserted mid-instruction aborts the instruction. No further `regwrite`/`memwrite` occurs after the asynchronous assertion.
- Latency with `mem_ready` tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Other states ignore `mem_ready`.
- `pcen` in BEQEX is combinational on `zero` within the cycle.

## Test plan
- Reset hold: hold `rst_n`=0 with `mem_ready`=1 → alusrcb=01, pcen=1, irwrite=1, regwrite=0, memwrite=0. Release reset, apply `op`=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5.
- Fetch stall: `mem_ready`=0 for 3 cycles in FETCH → pcen=0 and irwrite=0 for those 3 cycles, then a 1-cycle pulse of both when `mem_ready`=1. DECODE is entered the following cycle.
- sw wait: `op`=101011 with `mem_ready` low for 2 cycles in MEMWR → memwrite=1 for 3 consecutive cycles with iord=1, then FETCH.
- beq: `op`=000100 with zero=1 → pcen=1, pcsrc=01 in cycle 3. Repeat with zero=0 → pcen=0. Both cases return to FETCH.
- Jump and illegal opcode: `op`=000010 → pcsrc=10, pcen=1 in cycle 3. `op`=111111 → illegal=1 for one cycle in DECODE, then FETCH, with no regwrite or memwrite.
- Mid-instruction reset: assert `rst_n`=0 asynchronously in RTYPEEX, between clock edges → outputs switch to FETCH values before the next edge, and regwrite never asserts.

Source files
------------

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multicycle MIPS main controller (Moore FSM, memory-ready stalls)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       illegal
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regwrite     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = 2'b00;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            FETCH: begin
                alusrcb      = 2'b01;
                irwrite      = mem_ready;
                w_pcwrite    = mem_ready;
                w_next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alusrcb = 2'b11;
                case (op)
                    c_op_lw,
                    c_op_sw:    w_next_state = MEMADR;
                    c_op_rtype: w_next_state = RTYPEEX;
                    c_op_beq:   w_next_state = BEQEX;
                    c_op_addi:  w_next_state = ADDIEX;
                    c_op_j:     w_next_state = JEX;
                    default: begin
                        w_next_state = FETCH;
                        illegal      = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                w_next_state = (op == c_op_sw) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord         = 1'b1;
                w_next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite     = 1'b1;
                w_next_state = FETCH;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite     = 1'b1;
                w_next_state = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca      = 1'b1;
                aluop        = 2'b10;
                w_next_state = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite     = 1'b1;
                w_next_state = FETCH;
            end
            BEQEX: begin
                alusrca      = 1'b1;
                aluop        = 2'b01;
                pcsrc        = 2'b01;
                w_branch     = 1'b1;
                w_next_state = FETCH;
            end
            ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                w_next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite     = 1'b1;
                w_next_state = FETCH;
            end
            JEX: begin
                pcsrc        = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = FETCH;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    assign pcen = w_pcwrite | (w_branch & zero);

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Table-driven self-checking bench for mc_control
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       illegal;

    mc_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output word:
    // {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc, aluop, iord, memtoreg, regdst, illegal}
    localparam logic [14:0] c_f1    = 15'b1_0_1_0_0_01_00_00_0_0_0_0;
    localparam logic [14:0] c_f0    = 15'b0_0_0_0_0_01_00_00_0_0_0_0;
    localparam logic [14:0] c_dec   = 15'b0_0_0_0_0_11_00_00_0_0_0_0;
    localparam logic [14:0] c_decil = 15'b0_0_0_0_0_11_00_00_0_0_0_1;
    localparam logic [14:0] c_madr  = 15'b0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [14:0] c_mrd   = 15'b0_0_0_0_0_00_00_00_1_0_0_0;
    localparam logic [14:0] c_mwb   = 15'b0_0_0_1_0_00_00_00_0_1_0_0;
    localparam logic [14:0] c_mwr   = 15'b0_1_0_0_0_00_00_00_1_0_0_0;
    localparam logic [14:0] c_rex   = 15'b0_0_0_0_1_00_00_10_0_0_0_0;
    localparam logic [14:0] c_rwb   = 15'b0_0_0_1_0_00_00_00_0_0_1_0;
    localparam logic [14:0] c_beq1  = 15'b1_0_0_0_1_00_01_01_0_0_0_0;
    localparam logic [14:0] c_beq0  = 15'b0_0_0_0_1_00_01_01_0_0_0_0;
    localparam logic [14:0] c_aex   = 15'b0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [14:0] c_awb   = 15'b0_0_0_1_0_00_00_00_0_0_0_0;
    localparam logic [14:0] c_jex   = 15'b1_0_0_0_0_00_10_00_0_0_0_0;

    localparam logic [5:0] c_rt   = 6'b000000;
    localparam logic [5:0] c_lw   = 6'b100011;
    localparam logic [5:0] c_sw   = 6'b101011;
    localparam logic [5:0] c_beq  = 6'b000100;
    localparam logic [5:0] c_addi = 6'b001000;
    localparam logic [5:0] c_j    = 6'b000010;
    localparam logic [5:0] c_bad  = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [14:0] outs();
        return {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc,
                aluop, iord, memtoreg, regdst, illegal};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic z, input logic mr, input logic [14:0] e);
        vec_t v;
        v.op = o; v.zero = z; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endtask

    // Any write strobe seen while the reset window is being exercised is an error.
    logic watch_writes = 1'b0;
    int   stray_writes = 0;
    always @(regwrite or memwrite) begin
        if (watch_writes && (regwrite || memwrite)) stray_writes++;
    end

    initial begin
        // lw, 5 cycles
        add(c_lw, 0, 1, c_f1);  add(c_lw, 0, 1, c_dec); add(c_lw, 0, 1, c_madr);
        add(c_lw, 0, 1, c_mrd); add(c_lw, 0, 1, c_mwb);
        // fetch stall 3 cycles, then R-type
        add(c_rt, 0, 0, c_f0);  add(c_rt, 0, 0, c_f0);  add(c_rt, 0, 0, c_f0);
        add(c_rt, 0, 1, c_f1);  add(c_rt, 0, 0, c_dec); add(c_rt, 0, 0, c_rex);
        add(c_rt, 0, 0, c_rwb);
        // sw with two wait cycles in MEMWR
        add(c_sw, 0, 1, c_f1);  add(c_sw, 0, 1, c_dec); add(c_sw, 0, 1, c_madr);
        add(c_sw, 0, 0, c_mwr); add(c_sw, 0, 0, c_mwr); add(c_sw, 0, 1, c_mwr);
        // beq taken / not taken
        add(c_beq, 0, 1, c_f1); add(c_beq, 0, 1, c_dec); add(c_beq, 1, 1, c_beq1);
        add(c_beq, 0, 1, c_f1); add(c_beq, 1, 1, c_dec); add(c_beq, 0, 1, c_beq0);
        // addi
        add(c_addi, 0, 1, c_f1); add(c_addi, 0, 1, c_dec); add(c_addi, 0, 1, c_aex);
        add(c_addi, 0, 1, c_awb);
        // j
        add(c_j, 0, 1, c_f1);   add(c_j, 0, 1, c_dec);  add(c_j, 0, 1, c_jex);
        // illegal opcode
        add(c_bad, 0, 1, c_f1); add(c_bad, 0, 1, c_decil);
        // lw with a MEMRD stall
        add(c_lw, 0, 1, c_f1);  add(c_lw, 0, 1, c_dec); add(c_lw, 0, 1, c_madr);
        add(c_lw, 0, 0, c_mrd); add(c_lw, 0, 1, c_mrd); add(c_lw, 0, 1, c_mwb);
        add(c_lw, 0, 0, c_f0);

        rst_n = 1'b0; op = c_lw; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        check("reset_hold_mr1", c_f1);
        mem_ready = 1'b0; #1;
        check("reset_hold_mr0", c_f0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].mr;
            #4;
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
        end

        // Mid-instruction asynchronous reset while in RTYPEEX
        op = c_rt; zero = 1'b0; mem_ready = 1'b1;
        #4; check("mid_fetch", c_f1);
        @(posedge clk); #1; #4; check("mid_decode", c_dec);
        @(posedge clk); #1; #4; check("mid_rtypeex", c_rex);
        watch_writes = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("mid_async_fetch", c_f1);
        @(posedge clk); #1; check("mid_held_fetch", c_f1);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        #4; check("post_reset_stall", c_f0);
        watch_writes = 1'b0;
        checks++;
        if (stray_writes != 0) begin
            errors++;
            $display("FAIL no_write_after_reset: got %0d write pulses expected 0", stray_writes);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
